// File: rtl/uart_boot_loader_ctrl.sv
// uart_boot_loader_ctrl: packs UART bytes into 32-bit words, writes them to instruction memory, then releases the core
module uart_boot_loader_ctrl #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           MAX_WORDS      = 4096,
  parameter int unsigned           TIMEOUT_CYCLES = 200000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_byte_i,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  core_rst_no,
  output logic                  boot_done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [31:0]           words_done_o
);
  typedef enum logic [1:0] {S_LEN, S_DATA, S_DONE, S_ERR} state_t;
  state_t state, state_d;
  logic [1:0] byte_cnt, code_d;
  logic [31:0] len, word, asm_d, wcnt, tcnt;
  logic started, active, take, last_byte, fire, load, overrun, timeout;
  assign active = state == S_LEN || state == S_DATA;
  assign take = rx_valid_i && (state == S_LEN || (state == S_DATA && wcnt != len));
  assign last_byte = take && byte_cnt == 2'd3;
  assign fire = mem_req_o && mem_gnt_i;
  assign load = state == S_DATA && last_byte && (!mem_req_o || mem_gnt_i);
  assign overrun = state == S_DATA && last_byte && mem_req_o && !mem_gnt_i;
  assign timeout = active && started && !rx_valid_i && tcnt == TIMEOUT_CYCLES - 1;
  assign mem_we_o = mem_req_o;
  assign mem_be_o = {4{mem_req_o}};
  assign mem_addr_o = BASE_ADDR + ADDR_WIDTH'({words_done_o[29:0], 2'b00});
  assign core_rst_no = state == S_DONE;
  assign boot_done_o = state == S_DONE;
  assign err_o = state == S_ERR;
  // lane insert shared by the length field and the data word
  always_comb begin
    asm_d = state == S_LEN ? len : word;
    asm_d[8*byte_cnt +: 8] = rx_byte_i;
  end
  always_comb begin
    state_d = state;
    code_d = 2'd0;
    if (timeout) begin
      state_d = S_ERR;
      code_d = 2'd2;
    end else if (state == S_LEN && last_byte) begin
      state_d = asm_d == 0 ? S_DONE : asm_d > MAX_WORDS ? S_ERR : S_DATA;
      code_d = asm_d > MAX_WORDS ? 2'd1 : 2'd0;
    end else if (overrun) begin
      state_d = S_ERR;
      code_d = 2'd3;
    end else if (state == S_DATA && fire && words_done_o + 1 == len) begin
      state_d = S_DONE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= S_LEN;
      byte_cnt <= '0;
      len <= '0;
      word <= '0;
      wcnt <= '0;
      tcnt <= '0;
      started <= 1'b0;
      mem_req_o <= 1'b0;
      mem_wdata_o <= '0;
      words_done_o <= '0;
      err_code_o <= '0;
    end else begin
      state <= state_d;
      if (state_d == S_ERR && state != S_ERR) err_code_o <= code_d;
      if (active && rx_valid_i) begin
        tcnt <= '0;
        started <= 1'b1;
      end else if (active && started) begin
        tcnt <= tcnt + 1;
      end
      if (take) begin
        byte_cnt <= byte_cnt + 1;
        if (state == S_LEN) len <= asm_d;
        else word <= asm_d;
      end
      if (fire) begin
        mem_req_o <= 1'b0;
        words_done_o <= words_done_o + 1;
      end
      if (load) begin
        mem_req_o <= 1'b1;
        mem_wdata_o <= asm_d;
        wcnt <= wcnt + 1;
      end
      if (state_d == S_ERR) mem_req_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_boot_loader_ctrl.sv
// tb_uart_boot_loader_ctrl: directed and randomized boot-load scenarios checked against an image-level model
module tb_uart_boot_loader_ctrl;
  localparam int TO = 50;
  logic clk = 0, rst_n = 0, rx_valid = 0, mem_gnt = 0;
  logic [7:0] rx_byte = 0;
  logic mem_req, mem_we, core_rst_n, boot_done, err;
  logic [3:0] mem_be;
  logic [31:0] mem_addr, mem_wdata, words_done;
  logic [1:0] err_code;
  int n_cmp = 0, n_bad = 0;
  int gmode = 0, gdelay = 0, rwait = 0;
  logic [63:0] obs[$];
  logic [7:0] img[$];
  logic hold_v = 0;
  logic [31:0] hold_a, hold_d;
  bit req_seen = 0;
  uart_boot_loader_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_valid_i(rx_valid), .rx_byte_i(rx_byte),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .core_rst_no(core_rst_n),
    .boot_done_o(boot_done), .err_o(err), .err_code_o(err_code), .words_done_o(words_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_word(input int i);
    return {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
  endfunction
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1;
    rx_byte = b;
    tick();
    rx_valid = 0;
    rx_byte = 8'($urandom);
    tick(gap);
  endtask
  task automatic send_len(input logic [31:0] n, input int gap);
    for (int k = 0; k < 4; k++) send(n[8*k +: 8], gap);
  endtask
  task automatic make_img(input int n);
    img.delete();
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
  endtask
  task automatic do_reset();
    rst_n = 0;
    tick(2);
    chk("rst_req", mem_req, 0);
    chk("rst_core", core_rst_n, 0);
    chk("rst_done", boot_done, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_words", words_done, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1;
    obs.delete();
    req_seen = 0;
  endtask
  task automatic wait_end();
    for (int i = 0; i < 3000 && !(boot_done || err); i++) tick();
  endtask
  task automatic check_writes(input int n);
    chk("n_writes", obs.size(), n);
    for (int i = 0; i < obs.size() && i < n; i++) begin
      chk("w_addr", obs[i][63:32], 4 * i);
      chk("w_data", obs[i][31:0], exp_word(i));
    end
  endtask
  task automatic expect_done(input int n);
    wait_end();
    chk("done", {core_rst_n, boot_done, err}, 3'b110);
    chk("words_done", words_done, n);
    check_writes(n);
  endtask
  // memory grant model: 0 always granted, 1 granted after gdelay waiting cycles, 2 never granted
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!mem_req) begin
        rwait = 0;
        mem_gnt = gmode == 0;
      end else if (gmode == 2) mem_gnt = 0;
      else if (gmode == 0 || rwait >= gdelay) begin
        mem_gnt = 1;
        rwait = 0;
      end else begin
        mem_gnt = 0;
        rwait++;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst_n || !mem_req) hold_v = 0;
    else begin
      req_seen = 1;
      chk("we_be", {27'd0, mem_we, mem_be}, 32'h1F);
      if (hold_v) begin
        chk("hold_addr", mem_addr, hold_a);
        chk("hold_data", mem_wdata, hold_d);
      end
      hold_v = !mem_gnt;
      hold_a = mem_addr;
      hold_d = mem_wdata;
      if (mem_gnt) obs.push_back({mem_addr, mem_wdata});
    end
  end
  initial begin
    int n, gap;
    do_reset();
    gmode = 0;
    img = '{8'h13, 8'h01, 8'h20, 8'h00};
    send_len(1, 0);
    for (int i = 0; i < 4; i++) send(img[i], 0);
    chk("req_latency", mem_req, 1);
    chk("core_held", core_rst_n, 0);
    tick();
    chk("core_release", core_rst_n, 1);
    chk("t1_word", exp_word(0), 32'h0020_0113);
    expect_done(1);
    do_reset();
    gmode = 1;
    gdelay = 5;
    make_img(3);
    send_len(3, 3);
    foreach (img[i]) send(img[i], 3);
    expect_done(3);
    do_reset();
    gmode = 0;
    send_len(32'h0000_1001, 0);
    tick(3);
    chk("len_err", {core_rst_n, err, err_code}, 4'b0101);
    chk("len_no_req", req_seen, 0);
    do_reset();
    gmode = 2;
    make_img(2);
    send_len(2, 0);
    for (int i = 0; i < 7; i++) send(img[i], 0);
    chk("ovr_before", err, 0);
    send(img[7], 0);
    chk("ovr_err", {err, err_code}, 3'b111);
    chk("ovr_req", mem_req, 0);
    chk("ovr_words", words_done, 0);
    do_reset();
    gmode = 0;
    tick(TO + 10);
    chk("idle_no_to", err, 0);
    make_img(2);
    send_len(2, 0);
    for (int i = 0; i < 5; i++) send(img[i], 0);
    tick(TO - 1);
    chk("to_early", err, 0);
    tick();
    chk("to_err", {err, err_code}, 3'b110);
    chk("to_core", core_rst_n, 0);
    do_reset();
    make_img(4);
    send_len(4, 1);
    for (int i = 0; i < 5; i++) send(img[i], 1);
    rst_n = 0;
    tick();
    chk("mid_rst", {mem_req, core_rst_n, err}, 0);
    chk("mid_rst_words", words_done, 0);
    do_reset();
    make_img(1);
    send_len(1, 0);
    foreach (img[i]) send(img[i], 0);
    expect_done(1);
    for (int r = 0; r < 8; r++) begin
      do_reset();
      n = $urandom_range(1, 6);
      gap = $urandom_range(0, 3);
      gmode = 1;
      gdelay = $urandom_range(0, 3);
      make_img(n);
      send_len(n, gap);
      foreach (img[i]) send(img[i], gap);
      tick(2);
      for (int i = 0; i < 4; i++) send(8'($urandom), 0);
      expect_done(n);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
